// File: rtl/ysyx_22040365_lsu.sv
// ysyx_22040365_lsu -- load/store unit between EX and WB.
//
// Accepts one instruction from EX. It either passes the EX result straight
// through or makes a single data-memory access over a req/gnt/rvalid bus.
// Load data is sign- or zero-extended. The write-back value is then offered
// to WB with a valid/ready handshake.
//
// Optional feature: define LSU_TIMEOUT_EN to add a WAIT-state response
// timeout (parameter TIMEOUT_CYC). When the timeout fires, the result is
// reported with out_buserr=1. Without the macro, WAIT waits indefinitely
// and out_buserr is tied to 0.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    EX handshake (in_ready only in IDLE)
//   ex_result, store_data  effective address or ALU value; rs2 for stores
//   mem_op, rd_idx, wen_rd operation code, destination register, write enable
//   mem_req/we/addr/wdata/wmask, mem_gnt, mem_rvalid, mem_rdata
//                          data-memory bus (8-byte aligned words)
//   out_valid / out_ready  WB handshake
//   out_rd_idx, out_wen, out_data, out_misalign, out_buserr
//                          write-back result and status
module ysyx_22040365_lsu #(
  parameter int DW = 64
`ifdef LSU_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] store_data,
  input  logic [3:0]    mem_op,
  input  logic [4:0]    rd_idx,
  input  logic          wen_rd,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [7:0]    mem_wmask,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_rd_idx,
  output logic          out_wen,
  output logic [DW-1:0] out_data,
  output logic          out_misalign,
  output logic          out_buserr
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] addr_q, wdata_q, res_q;
  logic [7:0]    wmask_q;
  logic [3:0]    op_q;
  logic [4:0]    rd_q;
  logic          wen_q, misalign_q, buserr_q;

  logic          is_load_in, is_store_in, misalign_in;
  logic [1:0]    size_in;
  logic [7:0]    base_mask;
  logic          accept, capture, timeout_hit;

  // Picks the addressed lane out of an aligned 8-byte word and extends it.
  function automatic logic [DW-1:0] load_extract(input logic [3:0]    op,
                                                 input logic [2:0]    off,
                                                 input logic [DW-1:0] rdata);
    logic [DW-1:0]        lane;
    logic signed [7:0]    b8;
    logic signed [15:0]   h16;
    logic signed [31:0]   w32;
    logic signed [DW-1:0] sext;
    lane = rdata >> {off, 3'b000};
    b8   = lane[7:0];
    h16  = lane[15:0];
    w32  = lane[31:0];
    case (op)
      4'd1:    sext = b8;
      4'd2:    sext = h16;
      4'd3:    sext = w32;
      4'd5:    sext = {{(DW-8){1'b0}}, lane[7:0]};
      4'd6:    sext = {{(DW-16){1'b0}}, lane[15:0]};
      4'd7:    sext = {{(DW-32){1'b0}}, lane[31:0]};
      default: sext = lane;
    endcase
    return sext;
  endfunction

  // Operation decode of the incoming EX instruction.
  always_comb begin
    is_load_in  = (mem_op >= 4'd1) && (mem_op <= 4'd7);
    is_store_in = (mem_op >= 4'd8) && (mem_op <= 4'd11);
    case (mem_op)
      4'd1, 4'd5, 4'd8:  size_in = 2'd0;
      4'd2, 4'd6, 4'd9:  size_in = 2'd1;
      4'd3, 4'd7, 4'd10: size_in = 2'd2;
      default:           size_in = 2'd3;
    endcase
    case (size_in)
      2'd0:    begin base_mask = 8'h01; misalign_in = 1'b0;                end
      2'd1:    begin base_mask = 8'h03; misalign_in = ex_result[0];        end
      2'd2:    begin base_mask = 8'h0F; misalign_in = |ex_result[1:0];     end
      default: begin base_mask = 8'hFF; misalign_in = |ex_result[2:0];     end
    endcase
    misalign_in = misalign_in && (is_load_in || is_store_in);
  end

  assign accept  = (state_q == IDLE) && in_valid;
  assign capture = ((state_q == REQ) && mem_gnt && mem_rvalid) ||
                   ((state_q == WAIT) && mem_rvalid);

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q;

  // Counts WAIT cycles without a response; cleared while the request is
  // outstanding, so it starts at zero on WAIT entry.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (state_q == REQ) cnt_q <= '0;
    else if ((state_q == WAIT) && !mem_rvalid) cnt_q <= cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == WAIT) && !mem_rvalid &&
                       (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid)
              state_d = (!(is_load_in || is_store_in) || misalign_in) ? DONE : REQ;
      REQ:  if (mem_gnt) state_d = mem_rvalid ? DONE : WAIT;
      WAIT: if (mem_rvalid || timeout_hit) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: reset returns to IDLE and discards any pending access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wen_q      <= 1'b0;
      misalign_q <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wen_q      <= wen_rd && !is_store_in && !misalign_in;
        misalign_q <= misalign_in;
        buserr_q   <= 1'b0;
      end else if (timeout_hit) begin
        wen_q    <= 1'b0;
        buserr_q <= 1'b1;
      end
    end
  end

  // Datapath latches: only observed through state-qualified outputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= ex_result;
      wdata_q <= store_data << {ex_result[2:0], 3'b000};
      wmask_q <= base_mask << ex_result[2:0];
      op_q    <= mem_op;
      rd_q    <= rd_idx;
      res_q   <= ex_result;
    end else if (capture) begin
      res_q <= load_extract(op_q, addr_q[2:0], mem_rdata);
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign mem_req      = (state_q == REQ);
  assign mem_we       = mem_req && op_q[3];
  assign mem_addr     = mem_req ? {addr_q[DW-1:3], 3'b000} : '0;
  assign mem_wdata    = (mem_req && op_q[3]) ? wdata_q : '0;
  assign mem_wmask    = (mem_req && op_q[3]) ? wmask_q : '0;
  assign out_valid    = (state_q == DONE);
  assign out_rd_idx   = out_valid ? rd_q : '0;
  assign out_wen      = out_valid && wen_q;
  assign out_data     = out_valid ? res_q : '0;
  assign out_misalign = out_valid && misalign_q;
`ifdef LSU_TIMEOUT_EN
  assign out_buserr   = out_valid && buserr_q;
`else
  assign out_buserr   = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22040365_lsu.sv
// Directed testbench for ysyx_22040365_lsu. Inputs change 1 ns after the
// rising edge; outputs are sampled at the same point.
module tb_ysyx_22040365_lsu;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, wen_rd;
  logic [63:0] ex_result, store_data, mem_addr, mem_wdata, mem_rdata, out_data;
  logic [3:0]  mem_op;
  logic [4:0]  rd_idx, out_rd_idx;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [7:0]  mem_wmask;
  logic        out_valid, out_ready, out_wen, out_misalign, out_buserr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

`ifdef LSU_TIMEOUT_EN
  ysyx_22040365_lsu #(.DW(64), .TIMEOUT_CYC(4)) dut (
`else
  ysyx_22040365_lsu #(.DW(64)) dut (
`endif
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ex_result(ex_result), .store_data(store_data), .mem_op(mem_op),
    .rd_idx(rd_idx), .wen_rd(wen_rd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_idx(out_rd_idx),
    .out_wen(out_wen), .out_data(out_data), .out_misalign(out_misalign),
    .out_buserr(out_buserr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] sd, input logic [4:0] rd, input logic w);
    in_valid = 1'b1; mem_op = op; ex_result = a; store_data = sd; rd_idx = rd; wen_rd = w;
    tick();
    in_valid = 1'b0; mem_op = 4'd0; ex_result = '0; store_data = '0;
  endtask

  // Load with immediate grant and response on the following cycle; ends in DONE.
  task automatic load_txn(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] rdata, input logic [63:0] exp);
    issue(op, a, 64'd0, 5'd7, 1'b1);
    check({tag, "_req"}, mem_req, 1'b1);
    check({tag, "_addr"}, mem_addr, {a[63:3], 3'b000});
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_wen"}, out_wen, 1'b1);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; ex_result = '0; store_data = '0; mem_op = '0;
    rd_idx = '0; wen_rd = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 64'd0);
    rst = 1'b0;
    tick();

    // Non-memory pass-through
    issue(4'd0, 64'h1234, 64'd0, 5'd5, 1'b1);
    check("nm_valid", out_valid, 1'b1);
    check("nm_data", out_data, 64'h1234);
    check("nm_rd", out_rd_idx, 5'd5);
    check("nm_wen", out_wen, 1'b1);
    check("nm_no_req", mem_req, 1'b0);
    check("nm_in_ready", in_ready, 1'b0);
    tick();
    check("nm_back_idle", in_ready, 1'b1);

    // Loads with sign/zero extension across lanes
    load_txn("lb",  4'd1, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    load_txn("lbu", 4'd5, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    load_txn("lh",  4'd2, 64'h8000_0004, 64'h0000_8001_0000_0000, 64'hFFFF_FFFF_FFFF_8001);
    load_txn("lw",  4'd3, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    load_txn("lwu", 4'd7, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    load_txn("ld",  4'd4, 64'h8000_0010, 64'hCAFE_BABE_1234_5678, 64'hCAFE_BABE_1234_5678);

    // SH with delayed grant, then grant and ack in the same cycle
    issue(4'd9, 64'h8000_0006, 64'hBEEF, 5'd3, 1'b1);
    tick();
    check("sh_req_held", mem_req, 1'b1);
    check("sh_we", mem_we, 1'b1);
    check("sh_addr", mem_addr, 64'h8000_0000);
    check("sh_wmask", mem_wmask, 8'hC0);
    check("sh_wdata", mem_wdata, 64'hBEEF_0000_0000_0000);
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check("sh_valid", out_valid, 1'b1);
    check("sh_wen", out_wen, 1'b0);
    tick();

    // SD full-word store
    issue(4'd11, 64'h8000_0008, 64'h1122_3344_5566_7788, 5'd4, 1'b1);
    check("sd_wmask", mem_wmask, 8'hFF);
    check("sd_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    check("sd_addr", mem_addr, 64'h8000_0008);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; tick(); mem_rvalid = 1'b0;
    check("sd_valid", out_valid, 1'b1);
    check("sd_wen", out_wen, 1'b0);
    tick();

    // Misaligned LW
    issue(4'd3, 64'h8000_0002, 64'd0, 5'd9, 1'b1);
    check("mis_valid", out_valid, 1'b1);
    check("mis_flag", out_misalign, 1'b1);
    check("mis_wen", out_wen, 1'b0);
    check("mis_no_req", mem_req, 1'b0);
    tick();
    check("mis_idle", in_ready, 1'b1);

    // Backpressure: result held stable while WB stalls
    out_ready = 1'b0;
    issue(4'd0, 64'hDEAD_BEEF, 64'd0, 5'd12, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", out_valid, 1'b1);
      check("bp_data", out_data, 64'hDEAD_BEEF);
      check("bp_rd", out_rd_idx, 5'd12);
      tick();
    end
    out_ready = 1'b1;
    check("bp_still_valid", out_valid, 1'b1);
    tick();
    check("bp_released", out_valid, 1'b0);

    // Reset while waiting for a response; the late response is ignored
    issue(4'd4, 64'h8000_0020, 64'd0, 5'd6, 1'b1);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    check("rw_in_wait", in_ready, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rw_in_ready", in_ready, 1'b1);
    check("rw_mem_req", mem_req, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
    tick();
    mem_rvalid = 1'b0; mem_rdata = '0;
    check("rw_stale_valid", out_valid, 1'b0);
    check("rw_stale_ready", in_ready, 1'b1);

    // Missing response
    issue(4'd4, 64'h8000_0018, 64'd0, 5'd8, 1'b1);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
`ifdef LSU_TIMEOUT_EN
    tick(); tick(); tick();
    check("to_not_yet", out_valid, 1'b0);
    tick();
    check("to_valid", out_valid, 1'b1);
    check("to_buserr", out_buserr, 1'b1);
    check("to_wen", out_wen, 1'b0);
    tick();
    check("to_idle", in_ready, 1'b1);
`else
    for (int i = 0; i < 100; i++) tick();
    check("nto_valid", out_valid, 1'b0);
    check("nto_waiting", in_ready, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    mem_rvalid = 1'b0;
    check("nto_done", out_valid, 1'b1);
    check("nto_data", out_data, 64'h0123_4567_89AB_CDEF);
    check("nto_buserr", out_buserr, 1'b0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
